// File: rtl/btn_debounce_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce_ctrl
// Purpose  : Push-button debouncer that arms an external delay counter and
//            commits a new level only if the input holds until it is done.
// Revision : 1.0 - initial release
// ============================================================================
module btn_debounce_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 200000,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_raw,
    input  logic             delay_done,
    input  logic             err_clr,
    output logic             delay_run,
    output logic             btn_clean,
    output logic             press_pulse,
    output logic             release_pulse,
    output logic [CNT_W-1:0] press_count,
    output logic             timeout_err
);

    localparam int                c_WD_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT_CYC - 1);
    localparam logic [c_WD_W-1:0] c_WD_SAT  = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_btn_sync;
    logic [SYNC_STAGES-1:0] r_done_sync;
    logic [c_WD_W-1:0]      r_wd;
    logic                   w_btn_s;
    logic                   w_done_s;
    logic [c_WD_W-1:0]      w_wd_inc;

    assign w_btn_s  = r_btn_sync[SYNC_STAGES-1];
    assign w_done_s = r_done_sync[SYNC_STAGES-1];
    assign w_wd_inc = (r_wd == c_WD_SAT) ? r_wd : r_wd + c_WD_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_sync  <= '0;
            r_done_sync <= '0;
        end else begin
            r_btn_sync  <= {r_btn_sync[SYNC_STAGES-2:0], btn_raw};
            r_done_sync <= {r_done_sync[SYNC_STAGES-2:0], delay_done};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_wd          <= '0;
            delay_run     <= 1'b0;
            btn_clean     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            press_count   <= '0;
            timeout_err   <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            // Clear first so a same-cycle timeout below overrides it.
            if (err_clr) begin
                timeout_err <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    r_wd <= '0;
                    // A done still high from the last run must fall before re-arming.
                    if (!w_done_s && (w_btn_s != btn_clean)) begin
                        r_state   <= S_WAIT;
                        delay_run <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (w_btn_s == btn_clean) begin
                        r_state   <= S_IDLE;
                        r_wd      <= '0;
                        delay_run <= 1'b0;
                    end else if (w_done_s) begin
                        r_state   <= S_DRAIN;
                        r_wd      <= '0;
                        delay_run <= 1'b0;
                        btn_clean <= ~btn_clean;
                        if (!btn_clean) begin
                            press_pulse <= 1'b1;
                            press_count <= press_count + CNT_W'(1);
                        end else begin
                            release_pulse <= 1'b1;
                        end
                    end else if (r_wd == c_WD_LAST) begin
                        r_state     <= S_IDLE;
                        r_wd        <= '0;
                        delay_run   <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        r_wd <= w_wd_inc;
                    end
                end
                S_DRAIN: begin
                    if (!w_done_s) begin
                        r_state <= S_IDLE;
                        r_wd    <= '0;
                    end else if (r_wd == c_WD_LAST) begin
                        r_state     <= S_IDLE;
                        r_wd        <= '0;
                        timeout_err <= 1'b1;
                    end else begin
                        r_wd <= w_wd_inc;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_wd      <= '0;
                    delay_run <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_btn_debounce_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_btn_debounce_ctrl
// Purpose  : Scoreboard bench for btn_debounce_ctrl with a delay counter model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_btn_debounce_ctrl;

    logic       clk;
    logic       rst_n;
    logic       btn_raw;
    logic       delay_done;
    logic       err_clr;
    logic       delay_run;
    logic       btn_clean;
    logic       press_pulse;
    logic       release_pulse;
    logic [7:0] press_count;
    logic       timeout_err;

    typedef struct packed {
        logic       press;
        logic [7:0] cnt;
    } ev_t;

    ev_t         sb[$];
    ev_t         mon_ev;
    int          n_vec;
    int          n_err;
    int          n_run_fall;
    int          n_press;
    int          n_release;
    logic        run_prev;
    logic        model_en;
    int unsigned mdl_cnt;
    logic [7:0]  exp_cnt;
    logic        exp_clean;

    btn_debounce_ctrl #(
        .SYNC_STAGES (2),
        .TIMEOUT_CYC (64),
        .CNT_W       (8)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_raw       (btn_raw),
        .delay_done    (delay_done),
        .err_clr       (err_clr),
        .delay_run     (delay_run),
        .btn_clean     (btn_clean),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .press_count   (press_count),
        .timeout_err   (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Delay counter: done 20 cycles after run rises, drops 1 cycle after run falls.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_cnt    <= 0;
            delay_done <= 1'b0;
        end else if (!delay_run) begin
            mdl_cnt    <= 0;
            delay_done <= 1'b0;
        end else if (model_en && !delay_done) begin
            if (mdl_cnt == 19) delay_done <= 1'b1;
            else               mdl_cnt    <= mdl_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Output side of the scoreboard: every pulse must match the oldest pending event.
    always @(negedge clk) begin
        if (rst_n) begin
            if (press_pulse || release_pulse) begin
                check("pulse_excl", 32'(press_pulse & release_pulse), 0);
                check("sb_pending", 32'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    mon_ev = sb.pop_front();
                    check("ev_kind", 32'(press_pulse), 32'(mon_ev.press));
                    check("ev_clean", 32'(btn_clean), 32'(mon_ev.press));
                    check("ev_count", 32'(press_count), 32'(mon_ev.cnt));
                end
            end
            if (run_prev && !delay_run) n_run_fall++;
            if (press_pulse) n_press++;
            if (release_pulse) n_release++;
        end
        run_prev = delay_run;
    end

    task automatic set_btn(input logic v);
        ev_t e;
        @(negedge clk);
        btn_raw = v;
        if (v !== exp_clean) begin
            if (v) exp_cnt++;
            e.press = v;
            e.cnt   = exp_cnt;
            sb.push_back(e);
            exp_clean = v;
        end
    endtask

    task automatic wait_run(input logic v, input string tag);
        int k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (delay_run !== v && k < 200);
        check(tag, 32'(delay_run), 32'(v));
    endtask

    task automatic wait_done();
        int k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (!delay_done && k < 100);
        check("done_seen", 32'(delay_done), 1);
    endtask

    task automatic do_reset();
        check("sb_drained", 32'(sb.size()), 0);
        @(negedge clk);
        rst_n   = 1'b0;
        btn_raw = 1'b0;
        err_clr = 1'b0;
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        exp_cnt   = 8'd0;
        exp_clean = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int f0;
        int p0;
        int r0;
        n_vec = 0; n_err = 0; n_run_fall = 0; n_press = 0; n_release = 0;
        run_prev = 1'b0; rst_n = 1'b0; btn_raw = 1'b0; err_clr = 1'b0;
        model_en = 1'b1; exp_cnt = 8'd0; exp_clean = 1'b0;

        repeat (3) @(posedge clk); #1;
        check("rst_run", 32'(delay_run), 0);
        check("rst_clean", 32'(btn_clean), 0);
        check("rst_press", 32'(press_pulse), 0);
        check("rst_release", 32'(release_pulse), 0);
        check("rst_count", 32'(press_count), 0);
        check("rst_err", 32'(timeout_err), 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Clean press with edge-accurate latency checks
        set_btn(1'b1);
        @(posedge clk); #1; check("run_e1", 32'(delay_run), 0);
        @(posedge clk); #1; check("run_e2", 32'(delay_run), 0);
        @(posedge clk); #1; check("run_e3", 32'(delay_run), 1);
        wait_done();
        repeat (2) @(posedge clk); #1;
        check("clean_d2", 32'(btn_clean), 0);
        @(posedge clk); #1;
        check("clean_d3", 32'(btn_clean), 1);
        check("pulse_d3", 32'(press_pulse), 1);
        check("run_low_d3", 32'(delay_run), 0);
        check("count_d3", 32'(press_count), 1);
        @(posedge clk); #1;
        check("pulse_d4", 32'(press_pulse), 0);
        repeat (40) @(negedge clk);

        // Release
        r0 = n_release;
        set_btn(1'b0);
        repeat (40) @(negedge clk);
        check("rel_clean", 32'(btn_clean), 0);
        check("rel_count", 32'(press_count), 1);
        check("rel_pulses", 32'(n_release - r0), 1);

        // Bounce: 5 toggles, 4 cycles apart, ending high
        f0 = n_run_fall; p0 = n_press;
        set_btn(1'b1);
        repeat (4) @(negedge clk); btn_raw = 1'b0;
        repeat (4) @(negedge clk); btn_raw = 1'b1;
        repeat (4) @(negedge clk); btn_raw = 1'b0;
        repeat (4) @(negedge clk); btn_raw = 1'b1;
        repeat (4) @(negedge clk);
        check("bnc_falls", 32'(n_run_fall - f0), 2);
        check("bnc_run", 32'(delay_run), 1);
        repeat (40) @(negedge clk);
        check("bnc_presses", 32'(n_press - p0), 1);
        check("bnc_count", 32'(press_count), 2);
        check("bnc_clean", 32'(btn_clean), 1);
        set_btn(1'b0);
        repeat (40) @(negedge clk);

        // Counter wrap from reset
        do_reset();
        for (int i = 1; i <= 257; i++) begin
            set_btn(1'b1);
            repeat (40) @(negedge clk);
            if (i == 256) check("wrap_256", 32'(press_count), 0);
            if (i == 257) check("wrap_257", 32'(press_count), 1);
            set_btn(1'b0);
            repeat (40) @(negedge clk);
        end

        // Watchdog: delay counter never answers
        do_reset();
        model_en = 1'b0;
        @(negedge clk); btn_raw = 1'b1;
        wait_run(1'b1, "wd_run_up");
        repeat (63) @(posedge clk); #1;
        check("wd_err_pre", 32'(timeout_err), 0);
        check("wd_run_pre", 32'(delay_run), 1);
        @(posedge clk); #1;
        check("wd_err_set", 32'(timeout_err), 1);
        check("wd_run_drop", 32'(delay_run), 0);
        check("wd_clean", 32'(btn_clean), 0);
        @(posedge clk); #1;
        check("wd_rewait", 32'(delay_run), 1);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        check("wd_cleared", 32'(timeout_err), 0);
        @(negedge clk); err_clr = 1'b1;
        wait_run(1'b0, "wd_run_drop2");
        check("wd_set_wins", 32'(timeout_err), 1);
        @(posedge clk); #1;
        check("wd_clr_held", 32'(timeout_err), 0);
        @(negedge clk); err_clr = 1'b0; btn_raw = 1'b0; model_en = 1'b1;
        repeat (10) @(negedge clk);

        // Reset asserted mid-WAIT
        do_reset();
        @(negedge clk); btn_raw = 1'b1;
        wait_run(1'b1, "mw_run_up");
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("mw_run_before", 32'(delay_run), 1);
        rst_n = 1'b0;
        #1;
        check("mw_run_async", 32'(delay_run), 0);
        check("mw_clean", 32'(btn_clean), 0);
        check("mw_count", 32'(press_count), 0);
        check("mw_err", 32'(timeout_err), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 8'd0; exp_clean = 1'b0;
        set_btn(1'b1);
        repeat (40) @(negedge clk);
        check("mw_post_clean", 32'(btn_clean), 1);
        check("mw_post_count", 32'(press_count), 1);

        check("sb_final", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
